// File: rtl/addsub_defs.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package addsub_defs;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : addsub_defs

// File: rtl/addsub_nibble.sv
// One 4-bit add/subtract slice; time-shared across cycles by the sequencer.
module addsub_nibble
   import addsub_defs::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                sub,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);

   logic [NIBBLE_W-1:0] w_b_eff;
   logic [NIBBLE_W:0]   w_sum;

   // Subtract is a + ~b + 1; the +1 arrives through the initial carry.
   always_comb begin
      w_b_eff = b ^ {NIBBLE_W{sub}};
      w_sum   = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(w_b_eff) + (NIBBLE_W+1)'(ci);
   end

   assign s  = w_sum[NIBBLE_W-1:0];
   assign co = w_sum[NIBBLE_W];

endmodule : addsub_nibble

// File: rtl/addsub_sequencer.sv
// Nibble-serial adder/subtractor: one 4-bit slice per cycle, LSB nibble first.
module addsub_sequencer
   import addsub_defs::*;
#(
   parameter int unsigned NIBBLES = 4
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          sub,
   input  logic [NIBBLES*NIBBLE_W-1:0]   op_a,
   input  logic [NIBBLES*NIBBLE_W-1:0]   op_b,
   output logic                          busy,
   output logic                          done,
   output logic [NIBBLES*NIBBLE_W-1:0]   result,
   output logic                          cout,
   output logic                          ovf
);

   localparam int unsigned W        = NIBBLES * NIBBLE_W;
   localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e              r_state;
   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
   logic                r_sub;
   logic                r_carry;
   logic [IDX_W-1:0]    r_idx;

   logic [NIBBLE_W-1:0] w_a_n;
   logic [NIBBLE_W-1:0] w_b_n;
   logic [NIBBLE_W-1:0] w_s;
   logic                w_co;
   logic                w_b_msb;
   logic                w_ovf;

   // Select the current nibble of each latched operand.
   assign w_a_n = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
   assign w_b_n = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

   addsub_nibble u_nibble (
      .a   (w_a_n),
      .b   (w_b_n),
      .sub (r_sub),
      .ci  (r_carry),
      .s   (w_s),
      .co  (w_co)
   );

   // Signed overflow, evaluated while the MSB nibble is in the slice.
   assign w_b_msb = r_b[W-1] ^ r_sub;
   assign w_ovf   = (r_a[W-1] == w_b_msb) && (w_s[NIBBLE_W-1] != r_a[W-1]);

   // Control FSM with registered outputs; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_sub   <= sub;
                  r_carry <= sub;
                  r_idx   <= '0;
                  busy    <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               result[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s;
               r_carry <= w_co;
               if (r_idx == LAST_IDX) begin
                  cout    <= w_co;
                  ovf     <= w_ovf;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : addsub_sequencer

// File: tb/tb_addsub_sequencer.sv
// Scoreboard bench for addsub_sequencer: directed vectors, decoupled monitor.
module tb_addsub_sequencer;
   import addsub_defs::*;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W       = NIBBLES * NIBBLE_W;

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   exp_t q[$];
   exp_t mon_e;
   int   n_vec  = 0;
   int   n_miss = 0;
   int   lat;

   addsub_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sub    (sub),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one request for a single cycle (call just after a negedge) and log its expectation.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] er, input logic eco, input logic eov);
      exp_t e;
      op_a  = a;
      op_b  = b;
      sub   = s;
      start = 1'b1;
      e.res = er;
      e.co  = eco;
      e.ov  = eov;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      sub   = 1'($urandom);
   endtask

   // Wait (bounded) for done; cyc is the total negedge count including 'already'.
   task automatic wait_done(input int already, output int cyc);
      cyc = -1;
      for (int i = already + 1; i <= already + 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cyc = i;
            return;
         end
      end
      check("done_timeout", 32'(done), 32'd1);
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (q.size() == 0) begin
               check("spurious_done", 32'(done), 32'd0);
            end else begin
               mon_e = q.pop_front();
               check("result", 32'(result), 32'(mon_e.res));
               check("cout",   32'(cout),   32'(mon_e.co));
               check("ovf",    32'(ovf),    32'(mon_e.ov));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_done",   32'(done),   32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout",   32'(cout),   32'd0);
      check("rst_ovf",    32'(ovf),    32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic add with latency check.
      issue(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
      check("busy_after_accept", 32'(busy), 32'd1);
      wait_done(1, lat);
      check("latency_add", 32'(lat), 32'd5);
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);

      // Subtract with borrow.
      issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      wait_done(1, lat);
      check("latency_sub", 32'(lat), 32'd5);
      @(negedge clk);

      // Signed overflow cases.
      issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      wait_done(1, lat);
      @(negedge clk);
      issue(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      wait_done(1, lat);
      @(negedge clk);

      // Wrap to zero, then results must hold while idle.
      issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      wait_done(1, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_result", 32'(result), 32'h0000);
         check("hold_cout",   32'(cout),   32'd1);
         check("hold_done",   32'(done),   32'd0);
      end

      // Start during the DONE cycle is ignored.
      issue(16'h3333, 16'h3333, 1'b1, 16'h0000, 1'b1, 1'b0);
      wait_done(1, lat);
      op_a  = 16'hAAAA;
      op_b  = 16'h1111;
      sub   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", 32'(busy), 32'd0);
      @(negedge clk);
      check("no_accept_after_done", 32'(busy), 32'd0);

      // Start during RUN is ignored and operands are not disturbed.
      issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
      op_a  = 16'hAAAA;
      op_b  = 16'hAAAA;
      sub   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(2, lat);
      check("latency_run_start", 32'(lat), 32'd5);
      @(negedge clk);
      check("no_requeue", 32'(busy), 32'd0);

      // Reset in RUN cycle 2 aborts without done; restart right away.
      op_a  = 16'h0005;
      op_b  = 16'h0005;
      sub   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy",   32'(busy),   32'd0);
      check("abort_done",   32'(done),   32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_cout",   32'(cout),   32'd0);
      check("abort_ovf",    32'(ovf),    32'd0);
      issue(16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0);
      check("accept_after_reset", 32'(busy), 32'd1);
      wait_done(1, lat);
      check("latency_after_reset", 32'(lat), 32'd5);
      @(negedge clk);

      // Reset has priority over a simultaneous start.
      rst   = 1'b1;
      start = 1'b1;
      op_a  = 16'h1111;
      op_b  = 16'h2222;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check("rst_priority_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("rst_priority_idle", 32'(busy), 32'd0);

      // Both-negative add overflowing to zero.
      issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      wait_done(1, lat);
      repeat (3) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_addsub_sequencer
